// File: rtl/c499_key_sequencer_if.sv
// rtl/c499_key_sequencer_if.sv - request/response handshake bundle for the c499 key sequencer
interface c499_key_sequencer_if #(
  parameter int IN_W  = 41,
  parameter int OUT_W = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [IN_W-1:0]  req_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [OUT_W-1:0] resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/c499_key_sequencer.sv
// rtl/c499_key_sequencer.sv - serial key loader with parity lockout and two-stage core pipeline
module c499_key_sequencer #(
  parameter int KEY_W     = 32,
  parameter int IN_W      = 41,
  parameter int OUT_W     = 32,
  parameter int MAX_FAILS = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_start,
  input  logic              i_key_bit_valid,
  input  logic              i_key_bit,
  input  logic              i_key_zeroize,
  c499_key_sequencer_if.slave bus,
  output logic [IN_W-1:0]   o_core_in,
  output logic [KEY_W-1:0]  o_core_key,
  input  logic [OUT_W-1:0]  i_core_out,
  output logic [2:0]        o_state,
  output logic [2:0]        o_fail_cnt
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int IDX_W = $clog2(KEY_W);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_READY   = 3'd3,
    S_ERROR   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [KEY_W-1:0]   r_key;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_parity;
  logic [2:0]         r_fail_cnt;
  logic               r_v1;
  logic               r_v2;
  logic [IN_W-1:0]    r_core_in;
  logic [OUT_W-1:0]   r_resp_data;

  logic               w_zeroize;
  logic               w_bit_take;
  logic               w_cnt_full;
  logic               w_parity_ok;
  logic [2:0]         w_fail_inc;
  logic [IDX_W-1:0]   w_idx;
  logic               w_adv2;
  logic               w_req_ready;
  logic               w_req_fire;

  // Zeroize cannot pull the block out of lockout; only reset does.
  assign w_zeroize   = i_key_zeroize && (r_state != S_LOCKOUT);
  assign w_bit_take  = (r_state == S_LOAD) && i_key_bit_valid;
  assign w_cnt_full  = (r_cnt == CNT_W'(KEY_W));
  assign w_parity_ok = ~((^r_key) ^ r_parity);
  assign w_fail_inc  = r_fail_cnt + 3'd1;
  assign w_idx       = r_cnt[IDX_W-1:0];

  assign w_adv2      = r_v1 && (!r_v2 || bus.resp_ready);
  assign w_req_ready = (r_state == S_READY) && (!r_v1 || w_adv2);
  assign w_req_fire  = bus.req_valid && w_req_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_zeroize) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (i_key_start) w_next_state = S_LOAD;
        S_LOAD:          if (w_bit_take && w_cnt_full) w_next_state = S_CHECK;
        S_CHECK: begin
          if (w_parity_ok)                        w_next_state = S_READY;
          else if (w_fail_inc == 3'(MAX_FAILS))   w_next_state = S_LOCKOUT;
          else                                    w_next_state = S_ERROR;
        end
        S_READY, S_LOCKOUT: w_next_state = r_state;
        default:            w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key      <= '0;
      r_cnt      <= '0;
      r_parity   <= 1'b0;
      r_fail_cnt <= 3'd0;
    end else if (w_zeroize) begin
      r_key <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (i_key_start) begin
            r_key <= '0;
            r_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_bit_take) begin
            if (!w_cnt_full) begin
              r_key[w_idx] <= i_key_bit;
              r_cnt        <= r_cnt + CNT_W'(1);
            end else begin
              r_parity <= i_key_bit;
            end
          end
        end
        S_CHECK: begin
          if (!w_parity_ok) begin
            r_key      <= '0;
            r_fail_cnt <= w_fail_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // S1 holds the word driving the core, S2 captures the core result one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_core_in   <= '0;
      r_resp_data <= '0;
    end else if (w_zeroize) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_v1      <= 1'b1;
        r_core_in <= bus.req_data;
      end else if (w_adv2) begin
        r_v1 <= 1'b0;
      end
      if (w_adv2) begin
        r_v2        <= 1'b1;
        r_resp_data <= i_core_out;
      end else if (bus.resp_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = r_v2;
  assign bus.resp_data  = r_resp_data;
  assign o_core_in      = r_core_in;
  assign o_core_key     = (r_state == S_READY) ? r_key : '0;
  assign o_state        = r_state;
  assign o_fail_cnt     = r_fail_cnt;

endmodule

// File: tb/tb_c499_key_sequencer.sv
// tb/tb_c499_key_sequencer.sv - scoreboard bench for the c499 key sequencer
`timescale 1ns/1ps
module tb_c499_key_sequencer;
  localparam int KEY_W = 32;
  localparam int IN_W  = 41;
  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_start = 1'b0;
  logic key_bit_valid = 1'b0;
  logic key_bit = 1'b0;
  logic key_zeroize = 1'b0;
  logic [IN_W-1:0]  core_in;
  logic [KEY_W-1:0] core_key;
  logic [OUT_W-1:0] core_out;
  logic [2:0]       state;
  logic [2:0]       fail_cnt;

  c499_key_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  always #5 clk = ~clk;

  // Stand-in for the locked core: output depends on the data word and the key.
  assign core_out = core_in[31:0] ^ {23'd0, core_in[40:32]} ^ core_key;

  c499_key_sequencer #(.KEY_W(KEY_W), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_FAILS(3)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_key_start     (key_start),
    .i_key_bit_valid (key_bit_valid),
    .i_key_bit       (key_bit),
    .i_key_zeroize   (key_zeroize),
    .bus             (bus),
    .o_core_in       (core_in),
    .o_core_key      (core_key),
    .i_core_out      (core_out),
    .o_state         (state),
    .o_fail_cnt      (fail_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  // Hand-computed responses under key 0xA5A5_0F0F.
  logic [IN_W-1:0]  vin  [8] = '{41'h0_0000_0000, 41'h0_FFFF_FFFF, 41'h0_A5A5_0F0F, 41'h0_0000_0001,
                                 41'h0_1234_5678, 41'h1_0000_0000, 41'h1FF_0000_0000, 41'h0_5A5A_F0F0};
  logic [OUT_W-1:0] vexp [8] = '{32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h0000_0000, 32'hA5A5_0F0E,
                                 32'hB791_5977, 32'hA5A5_0F0E, 32'hA5A5_0EF0, 32'hFFFF_FFFF};
  logic [IN_W-1:0]  bpin [4] = '{41'h0_0F0F_A5A5, 41'h0_0000_0000, 41'h0_FFFF_FFFF, 41'h0_FFFF_FFFF};
  logic [OUT_W-1:0] bpexp[4] = '{32'hAAAA_AAAA, 32'hA5A5_0F0F, 32'h5A5A_F0F0, 32'h5A5A_F0F0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic             stall_seen = 1'b0;
  logic [OUT_W-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (stall_seen) begin
      check("resp_hold_valid", bus.resp_valid, 1);
      check("resp_hold_data", bus.resp_data, stall_data);
    end
    stall_seen = rst_n && !key_zeroize && bus.resp_valid && !bus.resp_ready;
    stall_data = bus.resp_data;
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected got %0h expected none", bus.resp_data);
      end else begin
        check("resp_data", bus.resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic load_key(input logic [31:0] k, input logic p, input logic [2:0] mid,
                          input logic [2:0] fin, input string tag);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int i = 0; i < 33; i++) begin
      key_bit_valid = 1'b1;
      key_bit       = (i < 32) ? k[i] : p;
      tick();
    end
    key_bit_valid = 1'b0;
    check({tag, "_mid_state"}, state, mid);
    check({tag, "_mid_req_ready"}, bus.req_ready, 0);
    tick();
    check({tag, "_end_state"}, state, fin);
  endtask

  // Offers data words with resp_ready held low; pushes expectations only on acceptance.
  task automatic fill_stalled(output int acc);
    acc = 0;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = bpin[(acc < 4) ? acc : 3];
      @(negedge clk);
      if (bus.req_ready) begin
        exp_q.push_back(bpexp[(acc < 4) ? acc : 3]);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int acc;
    bus.req_valid  = 1'b0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_core_key", core_key, 0);
    check("rst_core_in", core_in, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    load_key(32'hA5A5_0F0F, 1'b0, 3'd2, 3'd3, "good");
    check("good_core_key", core_key, 32'hA5A5_0F0F);
    check("good_fail_cnt", fail_cnt, 0);
    check("good_req_ready", bus.req_ready, 1);

    bus.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = vin[i];
      @(negedge clk);
      check("b2b_req_ready", bus.req_ready, 1);
      if (i < 2)  check("b2b_latency_empty", bus.resp_valid, 0);
      else        check("b2b_latency_stream", bus.resp_valid, 1);
      exp_q.push_back(vexp[i]);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    repeat (4) tick();
    check("b2b_drained", exp_q.size(), 0);

    fill_stalled(acc);
    check("bp_accepted", acc, 2);
    check("bp_req_ready", bus.req_ready, 0);
    check("bp_resp_valid", bus.resp_valid, 1);
    repeat (3) tick();
    bus.resp_ready = 1'b1;
    repeat (4) tick();
    check("bp_drained", exp_q.size(), 0);

    fill_stalled(acc);
    check("zero_fill", acc, 2);
    key_zeroize = 1'b1;
    tick();
    key_zeroize = 1'b0;
    exp_q.delete();
    check("zero_state", state, 0);
    check("zero_resp_valid", bus.resp_valid, 0);
    check("zero_core_key", core_key, 0);
    check("zero_req_ready", bus.req_ready, 0);
    check("zero_fail_kept", fail_cnt, 0);
    bus.resp_ready = 1'b1;
    repeat (4) tick();

    load_key(32'h0000_0001, 1'b0, 3'd2, 3'd4, "fail1");
    check("fail1_cnt", fail_cnt, 1);
    check("fail1_core_key", core_key, 0);
    load_key(32'h0000_0001, 1'b0, 3'd2, 3'd4, "fail2");
    check("fail2_cnt", fail_cnt, 2);
    load_key(32'h0000_0001, 1'b0, 3'd2, 3'd5, "fail3");
    check("fail3_cnt", fail_cnt, 3);
    check("fail3_core_key", core_key, 0);
    load_key(32'hA5A5_0F0F, 1'b0, 3'd5, 3'd5, "locked");
    check("locked_core_key", core_key, 0);
    key_zeroize = 1'b1;
    tick();
    key_zeroize = 1'b0;
    check("locked_zeroize_state", state, 5);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("unlock_state", state, 0);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      key_bit_valid = 1'b1;
      key_bit       = 1'b1;
      tick();
    end
    key_bit_valid = 1'b0;
    check("midload_state", state, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_state", state, 0);
    check("midrst_fail_cnt", fail_cnt, 0);
    check("midrst_core_key", core_key, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_resp_valid", bus.resp_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    load_key(32'hA5A5_0F0F, 1'b0, 3'd2, 3'd3, "reload");
    check("reload_core_key", core_key, 32'hA5A5_0F0F);
    bus.req_valid = 1'b1;
    bus.req_data  = vin[7];
    @(negedge clk);
    if (bus.req_ready) exp_q.push_back(vexp[7]);
    check("reload_req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (4) tick();
    check("reload_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/c499_key_sequencer.md
# c499_key_sequencer

Sequencing controller for the key-locked c499 single-error-correction core. Loads the 32-bit unlock key serially with parity check and failure lockout, then drives the purely combinational core under a valid/ready request stream. Registers core inputs and captures core outputs in a two-stage pipeline. Sits between the key-provisioning port and the locked core, which it instantiates by port connection only.

## Interface
- KEY_W, 32, key width; equals core `keyinput` count.
- IN_W, 41, core data-input width: {N137, N136..N129, N125..N1}.
- OUT_W, 32, core output width (N755..N724).
- MAX_FAILS, 3, parity failures before permanent lockout; range 1..7.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_start  in  1  pulse; begins a key load from IDLE or ERROR.
- key_bit_valid  in  1  qualifies key_bit.
- key_bit  in  1  serial key bit, LSB first, then one even-parity bit.
- key_zeroize  in  1  clears key and pipeline.
- req_valid / req_ready  in/out  1  request handshake.
- req_data  in  IN_W  core input word.
- resp_valid / resp_ready  out/in  1  response handshake.
- resp_data  out  OUT_W  captured core output.
- core_in  out  IN_W  registered drive to core data inputs.
- core_key  out  KEY_W  drive to core `keyinput0..31`.
- core_out  in  OUT_W  combinational core result.
- state  out  3  IDLE=0, LOAD=1, CHECK=2, READY=3, ERROR=4, LOCKOUT=5.
- fail_cnt  out  3  parity failures since reset.

## Operation
- IDLE: key_start -> LOAD; bit counter cleared, key register cleared.
- LOAD: each key_bit_valid shifts key_bit into key[cnt] (cnt 0..31); the 33rd valid bit is latched as parity -> CHECK. key_start ignored in LOAD.
- CHECK (one cycle): if XOR(key, parity)==0 -> READY; else fail_cnt+1 and -> LOCKOUT when the new fail_cnt == MAX_FAILS, otherwise -> ERROR with key cleared.
- ERROR: key_start -> LOAD. LOCKOUT: absorbing; only rst_n exits.
- core_key = key when state==READY, else all-zero. A wrong key is never exposed outside READY.
- Pipeline, READY only: S1 register {v1, core_in}; S2 register {v2, resp_data}.
  - adv2 = v1 & (!v2 | resp_ready).
  - req_ready = (state==READY) & (!v1 | adv2).
  - On a req handshake, S1 loads req_data. On adv2, S2 loads core_out.
  - Sustains one request per cycle while resp_ready stays high.
- resp_valid = v2. resp_data holds stable while resp_valid & !resp_ready.
- key_zeroize (any state except LOCKOUT): next cycle key=0, cnt=0, v1=v2=0, state=IDLE. In-flight results are dropped. fail_cnt is kept. Has priority over every other event in the same cycle.
- core_in holds its last value when v1 drops. It resets to 0.

## Timing
- Reset: state=IDLE, key=0, core_key=0, core_in=0, v1=v2=0, resp_valid=0, resp_data=0, req_ready=0, fail_cnt=0.
- Key load: parity bit accepted at edge t -> CHECK during t+1 -> READY or ERROR at t+2. req_ready can first be 1 in cycle t+2.
- Request accepted at edge t -> core_in valid after t -> resp_valid=1 after edge t+1 (latency 2).
- Backpressure: with resp_ready=0, at most two requests are accepted (S1+S2 full). req_ready then drops in the cycle after the second acceptance.
- key_bit_valid outside LOAD is ignored. The bit counter does not wrap.
- Simultaneous req handshake and key_zeroize: zeroize wins and the request is discarded.
- Simultaneous resp handshake and adv2: S2 is replaced with no bubble.

## Test plan
- Load key 0xA5A5_0F0F with parity 0 -> state 3 at parity edge+2; core_key=0xA5A5_0F0F; fail_cnt=0.
- Load 0x0000_0001 with parity 0 three times (MAX_FAILS=3) -> ERROR, ERROR, then state 5. Further key_start stays in 5; core_key=0.
- READY, resp_ready=1, 8 back-to-back requests -> req_ready constant 1. Each resp_data equals core_out for its request, 2 cycles after acceptance, in order.
- READY, resp_ready=0, req_valid held -> exactly 2 accepted; req_ready=0. Releasing resp_ready returns both responses in order with resp_data stable while stalled.
- key_zeroize while v1=v2=1 -> next cycle state=0, resp_valid=0, core_key=0; no response emitted afterward.
- rst_n asserted mid-LOAD after 17 bits -> all outputs at reset values immediately. A fresh load with a valid key reaches READY.
